// File: rtl/spart_tx.sv
// spart_tx: transmit half of the SPART serial port.
// Takes bytes from the I/O bus into a one-byte buffer and sends each one as an
// 8N1 frame on o_txd. Every bit lasts OVERSAMPLE baud-enable pulses.
// Optional feature: define SPART_TX_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit.
module spart_tx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_baud_en,
    input  logic       i_iocs,
    input  logic       i_iorw,
    input  logic [1:0] i_ioaddr,
    input  logic [7:0] i_data,
    output logic       o_tbr,
    output logic       o_busy,
    output logic       o_txd
);

    localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef SPART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state_q, state_nxt;
    logic [TICK_W-1:0]      tick_q, tick_nxt;
    logic [BIT_W-1:0]       bit_q, bit_nxt;
    logic [DATA_BITS-1:0]   shift_q, shift_nxt;
    logic [DATA_BITS-1:0]   buf_q, buf_nxt;
    logic                   tbr_q, tbr_nxt;
    logic                   txd_q, txd_nxt;
    logic                   busy_q, busy_nxt;
`ifdef SPART_TX_PARITY_EN
    logic                   parity_q, parity_nxt;
`endif

    logic wr_c;
    logic bit_end_c;

    assign o_tbr  = tbr_q;
    assign o_busy = busy_q;
    assign o_txd  = txd_q;

    // Next-state and output logic: bus write into the buffer, then frame sequencing.
    always_comb begin
        state_nxt = state_q;
        tick_nxt  = tick_q;
        bit_nxt   = bit_q;
        shift_nxt = shift_q;
        buf_nxt   = buf_q;
        tbr_nxt   = tbr_q;
        txd_nxt   = txd_q;
`ifdef SPART_TX_PARITY_EN
        parity_nxt = parity_q;
`endif

        wr_c      = i_iocs && !i_iorw && (i_ioaddr == 2'b00);
        bit_end_c = i_baud_en && (tick_q == TICK_LAST);

        // A write lands only in an empty buffer; otherwise it is silently dropped.
        if (wr_c && tbr_q) begin
            buf_nxt = DATA_BITS'(i_data);
            tbr_nxt = 1'b0;
        end

        // Tick counter runs only while framing and wraps at every bit boundary.
        if (state_q != IDLE && i_baud_en) begin
            tick_nxt = bit_end_c ? '0 : tick_q + TICK_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!tbr_q) begin
                    state_nxt = START;
                    shift_nxt = buf_q;
                    tbr_nxt   = 1'b1;
                    txd_nxt   = 1'b0;
                    tick_nxt  = '0;
`ifdef SPART_TX_PARITY_EN
                    parity_nxt = 1'b0;
`endif
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_nxt = DATA;
                    txd_nxt   = shift_q[0];
                    shift_nxt = shift_q >> 1;
                    bit_nxt   = '0;
`ifdef SPART_TX_PARITY_EN
                    parity_nxt = shift_q[0];
`endif
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    if (bit_q == BIT_LAST) begin
`ifdef SPART_TX_PARITY_EN
                        state_nxt = PARITY;
                        txd_nxt   = parity_q;
`else
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
`endif
                    end else begin
                        txd_nxt   = shift_q[0];
                        shift_nxt = shift_q >> 1;
                        bit_nxt   = bit_q + BIT_W'(1);
`ifdef SPART_TX_PARITY_EN
                        parity_nxt = parity_q ^ shift_q[0];
`endif
                    end
                end
            end
`ifdef SPART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_c) begin
                    state_nxt = STOP;
                    txd_nxt   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end_c) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                txd_nxt   = 1'b1;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            buf_q   <= '0;
            tbr_q   <= 1'b1;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SPART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            tick_q  <= tick_nxt;
            bit_q   <= bit_nxt;
            shift_q <= shift_nxt;
            buf_q   <= buf_nxt;
            tbr_q   <= tbr_nxt;
            txd_q   <= txd_nxt;
            busy_q  <= busy_nxt;
`ifdef SPART_TX_PARITY_EN
            parity_q <= parity_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_spart_tx.sv
// tb_spart_tx: bench for spart_tx with OVERSAMPLE=4.
// A buffer/line occupancy model predicts o_tbr and o_busy; accepted bytes are
// queued and a serial-line decoder checks every bit of every frame.
module tb_spart_tx;

    localparam int OS = 4;
`ifdef SPART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       rst;
    logic       i_baud_en;
    logic       i_iocs;
    logic       i_iorw;
    logic [1:0] i_ioaddr;
    logic [7:0] i_data;
    logic       o_tbr;
    logic       o_busy;
    logic       o_txd;

    spart_tx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_baud_en (i_baud_en),
        .i_iocs    (i_iocs),
        .i_iorw    (i_iorw),
        .i_ioaddr  (i_ioaddr),
        .i_data    (i_data),
        .o_tbr     (o_tbr),
        .o_busy    (o_busy),
        .o_txd     (o_txd)
    );

    int n_pass   = 0;
    int n_checks = 0;

    logic [7:0] exp_q[$];
    int  m_left  = 0;
    bit  m_full  = 0;
    bit  abort   = 0;
    bit  chk_en  = 0;
    int  frames  = 0;
    int  gap     = 0;
    int  last_gap = -1;
    bit  in_frame = 0;
    int  baud_mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Baud-enable generator: every clk, one in three clks, or random.
    initial begin
        int div;
        div = 0;
        i_baud_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (baud_mode)
                0: i_baud_en = 1'b1;
                1: begin
                    div = (div == 2) ? 0 : div + 1;
                    i_baud_en = (div == 2);
                end
                default: i_baud_en = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Reference model: one-byte buffer plus a line that stays busy for NB*OS pulses per frame.
    initial forever begin
        bit wr_ok;
        @(posedge clk);
        if (!rst) begin
            m_full = 0;
            m_left = 0;
            exp_q.delete();
            abort  = 1;
            chk_en = 1;
        end else begin
            wr_ok = i_iocs && !i_iorw && (i_ioaddr == 2'b00) && !m_full;
            if (m_left == 0 && m_full) begin
                m_left = NB * OS;
                m_full = 0;
            end else if (m_left > 0 && i_baud_en) begin
                m_left--;
            end
            if (wr_ok) begin
                m_full = 1;
                exp_q.push_back(i_data);
            end
        end
    end

    // Line monitor: checks buffer/busy flags every cycle and decodes frames off o_txd.
    initial forever begin
        logic [7:0] cur;
        logic       exp_bits [0:NB-1];
        int  bidx, pcnt, bad_val;
        bit  bad;
        @(negedge clk);
        if (chk_en) begin
            check(o_tbr === !m_full, "tbr", int'(o_tbr), int'(!m_full));
            check(o_busy === (m_left != 0), "busy", int'(o_busy), int'(m_left != 0));
            if (abort) begin
                in_frame = 0;
                abort = 0;
                gap = 0;
            end
            if (!in_frame) begin
                if (o_txd !== 1'b0) begin
                    gap++;
                end else if (exp_q.size() == 0) begin
                    check(1'b0, "spurious_start", 0, 1);
                end else begin
                    cur = exp_q.pop_front();
                    exp_bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) exp_bits[i+1] = cur[i];
`ifdef SPART_TX_PARITY_EN
                    exp_bits[9] = ^cur;
`endif
                    exp_bits[NB-1] = 1'b1;
                    in_frame = 1;
                    bidx = 0;
                    pcnt = 0;
                    bad = 0;
                    bad_val = 0;
                    last_gap = gap;
                end
            end
            if (in_frame) begin
                if (o_txd !== exp_bits[bidx]) begin
                    bad = 1;
                    bad_val = (o_txd === 1'b1) ? 1 : (o_txd === 1'b0) ? 0 : 9;
                end
                if (i_baud_en) pcnt++;
                if (pcnt == OS) begin
                    check(!bad, $sformatf("frame_bit byte=%02h bit=%0d", cur, bidx),
                          bad ? bad_val : int'(exp_bits[bidx]), int'(exp_bits[bidx]));
                    bidx++;
                    pcnt = 0;
                    bad = 0;
                    if (bidx == NB) begin
                        in_frame = 0;
                        frames++;
                        gap = 0;
                    end
                end
            end
        end
    end

    task automatic bus_idle();
        i_iocs   = 1'b0;
        i_iorw   = 1'b1;
        i_ioaddr = 2'b00;
        i_data   = 8'h00;
    endtask

    // One-cycle bus write to the transmit buffer address.
    task automatic do_write(input logic [7:0] d);
        @(posedge clk);
        #1;
        i_iocs   = 1'b1;
        i_iorw   = 1'b0;
        i_ioaddr = 2'b00;
        i_data   = d;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic wait_idle(input int limit);
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && !in_frame && m_left == 0 && !m_full) && t < limit) begin
            @(negedge clk);
            t++;
        end
        check(t < limit, "drain_timeout", t, limit);
    endtask

    initial begin
        int busy_cnt, tbr_low, t;
        rst = 1'b0;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Quiet line after reset.
        repeat (20) begin
            @(negedge clk);
            check(o_txd === 1'b1, "idle_txd", int'(o_txd), 1);
        end

        // Single frame with enable every clk: busy exactly NB*OS clks, tbr low one clk.
        baud_mode = 0;
        do_write(8'hA5);
        busy_cnt = 0;
        tbr_low = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_busy === 1'b1) busy_cnt++;
            if (o_tbr === 1'b0) tbr_low++;
        end
        check(busy_cnt == NB * OS, "busy_len", busy_cnt, NB * OS);
        check(tbr_low == 1, "tbr_low_len", tbr_low, 1);
        wait_idle(1000);
        check(frames == 1, "frames_a5", frames, 1);

        // Sparse enable: one pulse per three clks.
        baud_mode = 1;
        do_write(8'h01);
        wait_idle(2000);
        check(frames == 2, "frames_01", frames, 2);

        // Back-to-back frames with an overflow write that must be dropped.
        baud_mode = 0;
        do_write(8'h55);
        t = 0;
        while (o_tbr !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(t < 50, "tbr_rise_timeout", t, 50);
        do_write(8'h0F);
        do_write(8'hFF);
        wait_idle(2000);
        check(frames == 4, "frames_b2b", frames, 4);
        check(last_gap == 1, "b2b_gap", last_gap, 1);

        // Reset during data bit 3 of 0xC3.
        do_write(8'hC3);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check(o_txd === 1'b1, "rst_txd", int'(o_txd), 1);
        check(o_tbr === 1'b1, "rst_tbr", int'(o_tbr), 1);
        repeat (30) begin
            @(negedge clk);
            check(o_txd === 1'b1, "post_rst_txd", int'(o_txd), 1);
        end
        check(frames == 4, "frames_rst", frames, 4);

        // Parity-sensitive patterns (plain frames when parity is off).
        do_write(8'h07);
        wait_idle(1000);
        do_write(8'h03);
        wait_idle(1000);
        check(frames == 6, "frames_par", frames, 6);

        // Randomized bus traffic with random baud enables.
        baud_mode = 2;
        repeat (3000) begin
            @(posedge clk);
            #1;
            i_iocs   = ($urandom_range(0, 5) == 0);
            i_iorw   = ($urandom_range(0, 3) == 0);
            i_ioaddr = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            i_data   = 8'($urandom_range(0, 255));
        end
        @(posedge clk);
        #1;
        bus_idle();
        wait_idle(20000);
        check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
        check(frames > 6, "random_frames", frames, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
